lbp_banked: RTL



---
 rtl/lbp_banked_if.sv | 26 ++
 rtl/lbp_banked.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/lbp_banked_if.sv
// Prediction and update bus of the banked local branch predictor.
// The frontend drives the master side and the predictor implements the slave side.
interface lbp_banked_if #(
  parameter int VLEN         = 39,
  parameter int NR_BANKS     = 2,
  parameter int PHT_ROW_BITS = 9
);
  logic [VLEN-1:0]                  vpc;
  logic                             upd_valid;
  logic [VLEN-1:0]                  upd_pc;
  logic                             upd_taken;
  logic [PHT_ROW_BITS-1:0]          upd_index;
  logic [NR_BANKS-1:0]              pred_valid;
  logic [NR_BANKS-1:0]              pred_taken;
  logic [NR_BANKS*PHT_ROW_BITS-1:0] pred_index;

  modport master (
    output vpc, upd_valid, upd_pc, upd_taken, upd_index,
    input  pred_valid, pred_taken, pred_index
  );

  modport slave (
    input  vpc, upd_valid, upd_pc, upd_taken, upd_index,
    output pred_valid, pred_taken, pred_index
  );
endinterface

// File: rtl/lbp_banked.sv
// Banked local branch predictor: per-slot LHT/PHT banks, two-stage update, clear walk.
// Define LBP_PRED_BYPASS_EN to let predictions see the in-flight U1 write data.
module lbp_banked #(
  parameter int VLEN        = 39,
  parameter int NR_BANKS    = 2,
  parameter int LHT_ENTRIES = 256,
  parameter int PHT_ENTRIES = 1024,
  parameter int HIST_BITS   = 8,
  parameter int CTR_BITS    = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_bp_i,
  input  logic         debug_mode_i,
  lbp_banked_if.slave  bp,
  output logic         init_busy_o
);
  localparam int LHT_ROWS     = LHT_ENTRIES / NR_BANKS;
  localparam int PHT_ROWS     = PHT_ENTRIES / NR_BANKS;
  localparam int PHT_ROW_BITS = $clog2(PHT_ROWS);
  localparam int LHT_ROW_BITS = $clog2(LHT_ROWS);
  localparam int OFS          = $clog2(NR_BANKS) + 1;
  localparam int BANK_BITS    = (NR_BANKS > 1) ? $clog2(NR_BANKS) : 1;
  localparam int CLR_ROWS     = (LHT_ROWS > PHT_ROWS) ? LHT_ROWS : PHT_ROWS;
  localparam int ROW_BITS     = $clog2(CLR_ROWS);
  localparam int ROW_W1       = ROW_BITS + 1;

  localparam logic [ROW_BITS-1:0]  ROW_LAST  = ROW_BITS'(CLR_ROWS - 1);
  localparam logic [ROW_BITS:0]    LHT_LIMIT = ROW_W1'(LHT_ROWS);
  localparam logic [BANK_BITS-1:0] BANK_MASK = BANK_BITS'(NR_BANKS - 1);
  localparam logic [CTR_BITS-1:0]  CTR_MAX   = '1;
  localparam logic [CTR_BITS-1:0]  CTR_WEAK  = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                r_state, w_state_next;
  logic [ROW_BITS-1:0]   r_row, w_row_next;
  logic                  w_idle;

  logic                  r_u1_valid;
  logic [BANK_BITS-1:0]  r_u1_bank;
  logic [PHT_ROW_BITS-1:0] r_u1_pht_row;
  logic [LHT_ROW_BITS-1:0] r_u1_lht_row;
  logic                  r_u1_taken;
  logic [CTR_BITS-1:0]   r_u1_ctr;
  logic [HIST_BITS-1:0]  r_u1_hist;
  logic                  w_u1_we;
  logic [CTR_BITS-1:0]   w_u1_ctr_new;
  logic [HIST_BITS-1:0]  w_u1_hist_new;

  logic [BANK_BITS-1:0]  w_upd_bank;
  logic [LHT_ROW_BITS-1:0] w_upd_lht_row;
  logic [LHT_ROW_BITS-1:0] w_pred_lht_row;
  logic                  w_u0_accept;
  logic                  w_fwd_ctr, w_fwd_hist;
  logic [CTR_BITS-1:0]   w_u0_ctr;
  logic [HIST_BITS-1:0]  w_u0_hist;
  logic [NR_BANKS-1:0][CTR_BITS-1:0]     w_bank_ctr;
  logic [NR_BANKS-1:0][HIST_BITS-1:0]    w_bank_hist;
  logic [NR_BANKS-1:0][PHT_ROW_BITS-1:0] w_pred_index;
  logic                  w_unused;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_CLEAR;
      r_row   <= '0;
    end else begin
      r_state <= w_state_next;
      r_row   <= w_row_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_row_next   = r_row;
    case (r_state)
      S_IDLE: begin
        if (flush_bp_i) begin
          w_state_next = S_CLEAR;
          w_row_next   = '0;
        end
      end
      S_CLEAR: begin
        if (flush_bp_i) begin
          w_row_next = '0;
        end else if (r_row == ROW_LAST) begin
          w_state_next = S_IDLE;
          w_row_next   = '0;
        end else begin
          w_row_next = r_row + ROW_BITS'(1);
        end
      end
      default: w_state_next = S_CLEAR;
    endcase
  end

  assign w_idle      = (r_state == S_IDLE);
  assign init_busy_o = ~w_idle;

  assign w_upd_bank     = bp.upd_pc[1 +: BANK_BITS] & BANK_MASK;
  assign w_upd_lht_row  = bp.upd_pc[OFS +: LHT_ROW_BITS];
  assign w_pred_lht_row = bp.vpc[OFS +: LHT_ROW_BITS];
  assign w_u0_accept    = bp.upd_valid & ~debug_mode_i & w_idle;

  // A U1 write in the cycle a flush or reset lands is dropped, so it never races the clear walk.
  assign w_u1_we = r_u1_valid & w_idle & ~flush_bp_i & rst_ni;

  assign w_u1_ctr_new = r_u1_taken
                      ? ((r_u1_ctr == CTR_MAX) ? r_u1_ctr : r_u1_ctr + CTR_BITS'(1))
                      : ((r_u1_ctr == '0)      ? r_u1_ctr : r_u1_ctr - CTR_BITS'(1));
  assign w_u1_hist_new = {r_u1_hist[HIST_BITS-2:0], r_u1_taken};

  assign w_fwd_ctr  = w_u1_we && (r_u1_bank == w_upd_bank) && (r_u1_pht_row == bp.upd_index);
  assign w_fwd_hist = w_u1_we && (r_u1_bank == w_upd_bank) && (r_u1_lht_row == w_upd_lht_row);
  assign w_u0_ctr   = w_fwd_ctr  ? w_u1_ctr_new  : w_bank_ctr[w_upd_bank];
  assign w_u0_hist  = w_fwd_hist ? w_u1_hist_new : w_bank_hist[w_upd_bank];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_u1_valid <= 1'b0;
    else         r_u1_valid <= w_u0_accept;
  end

  always_ff @(posedge clk_i) begin
    r_u1_bank    <= w_upd_bank;
    r_u1_pht_row <= bp.upd_index;
    r_u1_lht_row <= w_upd_lht_row;
    r_u1_taken   <= bp.upd_taken;
    r_u1_ctr     <= w_u0_ctr;
    r_u1_hist    <= w_u0_hist;
  end

  for (genvar gi = 0; gi < NR_BANKS; gi++) begin : g_bank
    logic [CTR_BITS-1:0]     r_pht [PHT_ROWS];
    logic [HIST_BITS-1:0]    r_lht [LHT_ROWS];
    logic                    w_hit_bank;
    logic [HIST_BITS-1:0]    w_hist;
    logic [PHT_ROW_BITS-1:0] w_pht_row;
    logic [CTR_BITS-1:0]     w_ctr;

    assign w_hit_bank      = w_u1_we && (r_u1_bank == BANK_BITS'(gi));
    assign w_bank_ctr[gi]  = r_pht[bp.upd_index];
    assign w_bank_hist[gi] = r_lht[w_upd_lht_row];

`ifdef LBP_PRED_BYPASS_EN
    assign w_hist = (w_hit_bank && (r_u1_lht_row == w_pred_lht_row)) ? w_u1_hist_new
                                                                     : r_lht[w_pred_lht_row];
    assign w_ctr  = (w_hit_bank && (r_u1_pht_row == w_pht_row)) ? w_u1_ctr_new
                                                                : r_pht[w_pht_row];
`else
    assign w_hist = r_lht[w_pred_lht_row];
    assign w_ctr  = r_pht[w_pht_row];
`endif

    assign w_pht_row        = PHT_ROW_BITS'(w_hist) ^ bp.vpc[OFS +: PHT_ROW_BITS];
    assign w_pred_index[gi] = w_pht_row;
    assign bp.pred_taken[gi] = w_ctr[CTR_BITS-1] & w_idle;
    assign bp.pred_valid[gi] = w_idle;

    // History rows exist only below LHT_ROWS; the walk may run longer to cover the PHT.
    always_ff @(posedge clk_i) begin
      if (r_state == S_CLEAR) begin
        r_pht[r_row[PHT_ROW_BITS-1:0]] <= CTR_WEAK;
        if ({1'b0, r_row} < LHT_LIMIT) r_lht[r_row[LHT_ROW_BITS-1:0]] <= '0;
      end else if (w_hit_bank) begin
        r_pht[r_u1_pht_row] <= w_u1_ctr_new;
        r_lht[r_u1_lht_row] <= w_u1_hist_new;
      end
    end
  end

  assign bp.pred_index = w_pred_index;
  assign w_unused      = ^{bp.vpc, bp.upd_pc, r_u1_hist[HIST_BITS-1]};
endmodule
